iot_secure_mul_core: RTL and testbench

- Hardware constant-time unsigned multiplier that computes the 64-bit secure product of two 32-bit IoT sensor/device values.
- It is the synthesizable stage behind the secure-multiply operation. The sensor capture logic drives it upstream; the secure-result consumer sits downstream.
- It uses a radix-2 shift-add datapath with an operation time that does not depend on the operands: no early exit on zero, no skipped adds.
- Valid/ready handshake on both input and output.

---
 rtl/iot_secure_pkg.sv | 16 +
 rtl/iot_mul_step.sv | 25 ++
 rtl/iot_secure_mul_core.sv | 134 +++++++++++++
 tb/tb_iot_secure_mul_core.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/iot_secure_pkg.sv
// Shared definitions for the constant-time secure multiplier.
// Holds the default operand width, counter width, FSM state type and product type.
package iot_secure_pkg;

    localparam int unsigned IOT_WIDTH = 32;
    localparam int unsigned IOT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [2*IOT_WIDTH-1:0] product_t;

endpackage

// File: rtl/iot_mul_step.sv
// One radix-2 shift-add iteration, purely combinational.
// Ports:
//   acc, mcand, mplier        current accumulator / shifted multiplicand / multiplier
//   acc_nxt_c, mcand_nxt_c,   values after one step
//   mplier_nxt_c
// The masked add is always evaluated so every step costs the same regardless of operand bits.
module iot_mul_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_nxt_c,
    output logic [2*WIDTH-1:0] mcand_nxt_c,
    output logic [WIDTH-1:0]   mplier_nxt_c
);

    // Mask instead of branching so the adder is exercised every cycle.
    always_comb begin
        acc_nxt_c    = acc + (mcand & {(2*WIDTH){mplier[0]}});
        mcand_nxt_c  = mcand << 1;
        mplier_nxt_c = mplier >> 1;
    end

endmodule

// File: rtl/iot_secure_mul_core.sv
// Constant-time unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (op_a multiplicand, op_b multiplier)
//   out_valid / out_ready product handshake (product)
//   busy                  iteration in progress
//   op_count              completed products since reset, wrapping 16-bit counter
// Every operation takes exactly WIDTH steps after the accept edge; no early exit.
module iot_secure_mul_core
    import iot_secure_pkg::*;
#(
    parameter int unsigned WIDTH = IOT_WIDTH,
    parameter int unsigned CNT_W = IOT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [15:0]          op_count
);

    state_e               state_q;
    state_e               state_nxt;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [2*WIDTH-1:0]   acc_nxt_c;
    logic [2*WIDTH-1:0]   mcand_nxt_c;
    logic [WIDTH-1:0]     mplier_nxt_c;

    logic                 accept_c;
    logic                 last_step_c;
    logic                 handoff_c;

    iot_mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc          (acc_q),
        .mcand        (mcand_q),
        .mplier       (mplier_q),
        .acc_nxt_c    (acc_nxt_c),
        .mcand_nxt_c  (mcand_nxt_c),
        .mplier_nxt_c (mplier_nxt_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and handshake qualifiers.
    always_comb begin
        state_nxt   = state_q;
        accept_c    = 1'b0;
        last_step_c = 1'b0;
        handoff_c   = 1'b0;
        case (state_q)
            IDLE: begin
                accept_c = in_valid && in_ready;
                if (accept_c) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                last_step_c = (cnt_q == CNT_W'(WIDTH - 1));
                if (last_step_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                handoff_c = out_valid && out_ready;
                if (handoff_c) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; status flags track the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product   <= '0;
            op_count  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            busy      <= (state_nxt == BUSY);
            out_valid <= (state_nxt == DONE);

            if (accept_c) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, op_a};
                mplier_q <= op_b;
                cnt_q    <= '0;
            end

            if (state_q == BUSY) begin
                acc_q    <= acc_nxt_c;
                mcand_q  <= mcand_nxt_c;
                mplier_q <= mplier_nxt_c;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (last_step_c) begin
                    product <= acc_nxt_c;
                end
            end

            if (handoff_c) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_iot_secure_mul_core.sv
// Table-driven bench for iot_secure_mul_core: directed operand pairs with
// hand-computed products, plus reset-mid-operation and op_count wrap sequences.
module tb_iot_secure_mul_core;

    localparam int unsigned W       = 32;
    localparam int          LAT     = 32;
    localparam int          TIMEOUT = 100;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  product;
    logic            busy;
    logic [15:0]     op_count;

    iot_secure_mul_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        int             bp;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    int          n_vec;
    int          n_err;
    logic [15:0] exp_cnt;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Issue one operation, measure latency/busy, optionally hold back-pressure, then hand off.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] p, input int bp);
        int   edges;
        int   busy_cyc;
        int   waited;
        logic stable_ok;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        edges    = 0;
        busy_cyc = 0;
        while (!out_valid && edges < TIMEOUT) begin
            if (busy) busy_cyc++;
            if (edges == 5) begin
                op_a = $urandom;
                op_b = $urandom;
            end
            @(posedge clk); #1;
            edges++;
        end
        check("latency", 64'(edges), 64'(LAT));
        check("busy_cycles", 64'(busy_cyc), 64'(LAT));
        check("product", product, p);
        stable_ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op_a     = $urandom;
            op_b     = $urandom;
            @(posedge clk); #1;
            if (!out_valid || product !== p || in_ready) stable_ok = 1'b0;
        end
        if (bp > 0) check("backpressure_hold", 64'(stable_ok), 64'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        check("out_valid_after_handoff", 64'(out_valid), 64'd0);
        check("op_count", 64'(op_count), 64'(exp_cnt));
        check("in_ready_after_handoff", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("no_stray_accept", 64'(busy), 64'd0);
    endtask

    initial begin
        int   edges;
        logic saw_valid;

        n_vec     = 0;
        n_err     = 0;
        exp_cnt   = 16'd0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;

        vecs[0] = '{a: 32'd1234,       b: 32'd5678,       p: 64'd7006652,             bp: 0};
        vecs[1] = '{a: 32'd123456,     b: 32'd789012,     p: 64'd97408265472,         bp: 0};
        vecs[2] = '{a: 32'd0,          b: 32'd12345,      p: 64'd0,                   bp: 0};
        vecs[3] = '{a: 32'hFFFF_FFFF,  b: 32'h2,          p: 64'h1_FFFF_FFFE,         bp: 0};
        vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 64'hFFFF_FFFE_0000_0001, bp: 10};
        vecs[5] = '{a: 32'h8000_0000,  b: 32'h8000_0000,  p: 64'h4000_0000_0000_0000, bp: 3};
        vecs[6] = '{a: 32'd65535,      b: 32'd65537,      p: 64'd4294967295,          bp: 0};
        vecs[7] = '{a: 32'd7,          b: 32'd0,          p: 64'd0,                   bp: 1};

        // Values while reset is held.
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].bp);
        end

        // Reset asserted mid-operation must clear outputs at once and emit nothing afterwards.
        @(negedge clk);
        op_a     = 32'd999;
        op_b     = 32'd999;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_op_count", 64'(op_count), 64'd0);
        exp_cnt = 16'd0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        for (edges = 0; edges < 40; edges++) begin
            @(posedge clk); #1;
            if (out_valid || busy) saw_valid = 1'b1;
        end
        check("midrst_no_product", 64'(saw_valid), 64'd0);

        run_op(32'd1234, 32'd5678, 64'd7006652, 0);

        // Preload the counter to its top value, then the next handoff must wrap it.
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        exp_cnt = 16'hFFFF;
        run_op(32'd3, 32'd5, 64'd15, 0);
        run_op(32'd10, 32'd10, 64'd100, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the stimulus stalls somewhere unexpected.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
